mos6502_bus_initiator: RTL and testbench

- Synchronous 6502-style bus initiator: generates PHI2 and drives address, RS0, CS1, R/W and the data bus toward a 6530-compatible responder.
- Serves as the stimulus master for the RRIOT core on hardware-in-loop rigs and in simulation.
- Host side is a valid/ready request port plus a read-response strobe.
- Runs on a fast system clock; PHI2 is derived by division, so the responder sees a true two-phase bus.

---
 rtl/mos6502_bus_pkg.sv | 33 +++
 rtl/mos6502_phi_gen.sv | 45 ++++
 rtl/mos6502_bus_initiator.sv | 191 +++++++++++++++++++
 tb/tb_mos6502_bus_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502_bus_pkg.sv
// Shared types and constants for the 6502-style bus initiator.
// The bus FSM state, the PHI half-phase encoding, the reset-generator
// period count and the default PHI divider all live here so that the
// divider and the top-level FSM agree on them.
package mos6502_bus_pkg;

    // Bus-cycle FSM state: IDLE between cycles, ADDR during PHI1 of an
    // accepted cycle, DATA during PHI2 of an accepted cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Which half of the PHI2 period the divider is in (PH1 = PHI2 low).
    typedef enum logic {
        PH1 = 1'b0,
        PH2 = 1'b1
    } phase_t;

    // Number of full PHI2 periods the generated responder reset stays low.
    localparam int RES_PHI_CYCLES = 8;

    // Default number of clk cycles per PHI half-phase.
    localparam int PHI_DIV_DEFAULT = 4;

    // Legal divider range: at least two clks per half-phase so that the
    // first and last clk of a phase are distinct; the counter is 8 bits.
    function automatic bit phi_div_ok(input int div);
        return (div >= 2) && (div <= 255);
    endfunction

endpackage

// File: rtl/mos6502_phi_gen.sv
// PHI2 divider for the 6502-style bus initiator.
// Produces a free-running PHI2 (PHI_DIV clks low, then PHI_DIV clks high)
// and one-clk position strobes for the first and last clk of each
// half-phase. The strobes are decoded from the current counter value, so
// a register updated on a "last" strobe becomes visible together with the
// first clk of the following half-phase.
module mos6502_phi_gen
    import mos6502_bus_pkg::*;
#(
    parameter int PHI_DIV = PHI_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic phi2_o,
    output logic ph1_first,
    output logic ph1_last,
    output logic ph2_first,
    output logic ph2_last
);

    localparam logic [7:0] CNT_LAST = 8'(PHI_DIV - 1);

    logic [7:0] cnt;
    phase_t     phase;

    // Half-phase counter; the phase flips when the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 8'd0;
            phase <= PH1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= 8'd0;
            phase <= (phase == PH1) ? PH2 : PH1;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign phi2_o    = (phase == PH2);
    assign ph1_first = (phase == PH1) && (cnt == 8'd0);
    assign ph1_last  = (phase == PH1) && (cnt == CNT_LAST);
    assign ph2_first = (phase == PH2) && (cnt == 8'd0);
    assign ph2_last  = (phase == PH2) && (cnt == CNT_LAST);

endmodule

// File: rtl/mos6502_bus_initiator.sv
// 6502-style bus initiator driving a 6530-compatible responder.
// Host side: valid/ready request port plus a one-clk read-response strobe.
// Bus side: divided PHI2, address, RS0, CS1, R/W and a data bus split into
// drive value, drive enable and sample input.
//
// Optional feature macro: MOS6502_BUS_INITIATOR_RES_GEN_EN
//   When defined, adds res_n_o, a responder reset held low for
//   RES_PHI_CYCLES full PHI2 periods after rst; requests are refused
//   while it is low.
//
// Handshake: a request transfers on a clk where req_valid and req_ready are
// both high; req_ready is only raised on the last clk of a PHI2-high phase
// while no bus cycle is in its address phase, and the request fields are
// sampled on that clk only. rsp_valid is a single-clk pulse with no
// back-pressure; rsp_rdata holds until the next read completes.
//
// Cycle timeline for a request accepted at clk ta (the last PHI2 clk):
//   ta+1 .. ta+PHI_DIV          ADDR: address/RS0/R/W/CS1 driven
//   ta+PHI_DIV+1 .. ta+2*PHI_DIV DATA: write data driven / read sampled at end
//   ta+2*PHI_DIV+1              write data still driven one clk, or rsp_valid
module mos6502_bus_initiator
    import mos6502_bus_pkg::*;
#(
    parameter int PHI_DIV = PHI_DIV_DEFAULT,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rs0,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              phi2_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rs0_o,
    output logic              cs1_o,
    output logic              rw_o,
    output logic [DATA_W-1:0] db_o,
    output logic              db_oe,
    input  logic [DATA_W-1:0] db_i,
`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
    output logic              res_n_o,
`endif
    output logic [1:0]        dbg_state
);

    generate
        if (!phi_div_ok(PHI_DIV)) begin : g_bad_phi_div
            $error("mos6502_bus_initiator: PHI_DIV must be in 2..255");
        end
    endgenerate

    state_t            state;
    state_t            state_nx;
    logic              ph1_first;
    logic              ph1_last;
    logic              ph2_first;
    logic              ph2_last;
    logic              accept;
    logic              capture;
    logic              res_ok;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hold_q;

    mos6502_phi_gen #(
        .PHI_DIV (PHI_DIV)
    ) u_phi_gen (
        .clk       (clk),
        .rst       (rst),
        .phi2_o    (phi2_o),
        .ph1_first (ph1_first),
        .ph1_last  (ph1_last),
        .ph2_first (ph2_first),
        .ph2_last  (ph2_last)
    );

`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
    logic [3:0] res_cnt;
    logic       res_n_q;

    // Count completed PHI2 periods after rst; release the responder reset
    // on the edge that ends the last counted period, i.e. into a PHI1.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt <= 4'd0;
            res_n_q <= 1'b0;
        end else if (!res_n_q && ph2_last) begin
            if (res_cnt == 4'(RES_PHI_CYCLES - 1)) begin
                res_n_q <= 1'b1;
            end else begin
                res_cnt <= res_cnt + 4'd1;
            end
        end
    end

    assign res_n_o = res_n_q;
    assign res_ok  = res_n_q;
`else
    assign res_ok = 1'b1;
`endif

    assign accept  = req_valid && req_ready;
    assign capture = (state == DATA) && ph2_last && !we_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: a cycle walks ADDR -> DATA and either chains straight
    // into the next ADDR or drops back to IDLE at the end of PHI2.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = ADDR;
            ADDR:    if (ph1_last) state_nx = DATA;
            DATA:    if (ph2_last) state_nx = accept ? ADDR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: bus control levels and the request handshake.
    always_comb begin
        req_ready = ph2_last && res_ok && ((state == IDLE) || (state == DATA));
        cs1_o     = 1'b0;
        rw_o      = 1'b1;
        case (state)
            ADDR, DATA: begin
                cs1_o = 1'b1;
                rw_o  = ~we_q;
            end
            default: begin
                cs1_o = 1'b0;
                rw_o  = 1'b1;
            end
        endcase
        // Write data is driven through PHI2 and for one extra clk into the
        // next PHI1 so the responder sees hold time after PHI2 falls.
        db_oe = ((state == DATA) && we_q) || (hold_q && ph1_first);
    end

    assign dbg_state = state;

    // Bus datapath: request capture, write-data drive, read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_o    <= '0;
            rs0_o     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            db_o      <= '0;
            hold_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_o  <= req_addr;
                rs0_o   <= req_rs0;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            // db_o is loaded separately from wdata_q so that a chained
            // write cannot disturb the previous write's hold clk.
            if ((state == ADDR) && ph1_last && we_q) begin
                db_o <= wdata_q;
            end
            // hold_q marks "the last cycle was a write"; it only drives the
            // bus on the first PHI1 clk and is retired at the next PHI2.
            if ((state == DATA) && ph2_last && we_q) begin
                hold_q <= 1'b1;
            end else if (ph2_first) begin
                hold_q <= 1'b0;
            end
            rsp_valid <= capture;
            if (capture) begin
                rsp_rdata <= db_i;
            end
        end
    end

endmodule

// File: tb/tb_mos6502_bus_initiator.sv
// Self-checking bench for mos6502_bus_initiator.
// The reference model is a list of accepted transactions with their
// acceptance clk; every expected bus level is derived from where the
// current clk falls relative to each transaction's bus-cycle window.
module tb_mos6502_bus_initiator;

`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
    localparam int DIV      = 2;
    localparam int RES_CLKS = 16 * DIV;
`else
    localparam int DIV      = 4;
    localparam int RES_CLKS = 0;
`endif
    localparam int PER = 2 * DIV;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [9:0] req_addr;
    logic       req_rs0;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       phi2_o;
    logic [9:0] addr_o;
    logic       rs0_o;
    logic       cs1_o;
    logic       rw_o;
    logic [7:0] db_o;
    logic       db_oe;
    logic [7:0] db_i;
    logic [1:0] dbg_state;
`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
    logic       res_n_o;
`endif

    mos6502_bus_initiator #(
        .PHI_DIV (DIV),
        .ADDR_W  (10),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_rs0   (req_rs0),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .phi2_o    (phi2_o),
        .addr_o    (addr_o),
        .rs0_o     (rs0_o),
        .cs1_o     (cs1_o),
        .rw_o      (rw_o),
        .db_o      (db_o),
        .db_oe     (db_oe),
        .db_i      (db_i),
`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
        .res_n_o   (res_n_o),
`endif
        .dbg_state (dbg_state)
    );

    typedef struct {
        int         ta;
        logic       we;
        logic [9:0] addr;
        logic       rs0;
        logic [7:0] wdata;
        logic [7:0] cap;
    } txn_t;

    txn_t       txn_q[$];
    logic [7:0] exp_q[$];

    int         n_vec;
    int         n_bad;
    int         t;
    logic       rst_q;
    bit         checking;
    bit         db_fix;
    logic [7:0] db_fix_val;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clk index since the last reset edge; interval 0 is the first PHI1 clk.
    always @(posedge clk) begin
        rst_q <= rst;
        t     <= rst ? 0 : t + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d got=running want=finished", t);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / drivers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_we    = 1'($urandom);
        req_addr  = 10'($urandom);
        req_rs0   = 1'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // Present a request and hold it until the handshake completes.
    // Called and returns one time unit after a rising edge.
    task automatic do_req(input logic we, input logic [9:0] addr, input logic rs0,
                          input logic [7:0] wd);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_rs0   = rs0;
        req_wdata = wd;
        for (int i = 0; i < 40 * DIV && !done; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        scramble();
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_timeout t=%0d got=no_ready want=ready", t);
        end
    endtask

    // Responder: random data on the bus every clk unless pinned.
    initial begin
        db_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            db_i = db_fix ? db_fix_val : 8'($urandom);
        end
    end

    // ---------------- model + compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            logic       e_phi, e_ready, e_cs1, e_rw, e_oe, e_rs0, e_rv;
            logic [9:0] e_addr;
            logic [7:0] e_db, e_rd;
            int         ta;
            if (rst_q) begin
                txn_q.delete();
                exp_q.delete();
            end
            e_phi   = ((t / DIV) % 2) == 1;
            e_ready = ((t % PER) == PER - 1) && (t >= RES_CLKS);
            e_cs1 = 1'b0; e_rw = 1'b1; e_oe = 1'b0; e_rs0 = 1'b0; e_rv = 1'b0;
            e_addr = '0; e_db = '0; e_rd = '0;
            foreach (txn_q[i]) begin
                ta = txn_q[i].ta;
                if (ta < t) begin
                    e_addr = txn_q[i].addr;
                    e_rs0  = txn_q[i].rs0;
                end
                if (t >= ta + 1 && t <= ta + PER) begin
                    e_cs1 = 1'b1;
                    e_rw  = ~txn_q[i].we;
                    if (txn_q[i].we && t >= ta + DIV + 1) e_oe = 1'b1;
                end
                if (txn_q[i].we && t == ta + PER + 1) e_oe = 1'b1;
                if (txn_q[i].we && t >= ta + DIV + 1) e_db = txn_q[i].wdata;
                if (!txn_q[i].we && t >= ta + PER + 1) e_rd = txn_q[i].cap;
                if (!txn_q[i].we && t == ta + PER + 1) e_rv = 1'b1;
            end
            check("phi2", phi2_o, e_phi);
            check("req_ready", req_ready, e_ready);
            check("cs1", cs1_o, e_cs1);
            check("rw", rw_o, e_rw);
            check("db_oe", db_oe, e_oe);
            if (e_oe) check("db_o", db_o, e_db);
            check("addr", addr_o, e_addr);
            check("rs0", rs0_o, e_rs0);
            check("rsp_valid", rsp_valid, e_rv);
            check("rsp_rdata", rsp_rdata, e_rd);
`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
            check("res_n", res_n_o, (t >= RES_CLKS) ? 1'b1 : 1'b0);
`endif
            // Scoreboard of returned read data, in order.
            if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
                check("rsp_sb", rsp_rdata, exp_q.pop_front());
            end
            // Advance the model: responder sample, then acceptance.
            foreach (txn_q[i]) begin
                if (!txn_q[i].we && t == txn_q[i].ta + PER) begin
                    txn_q[i].cap = db_i;
                    exp_q.push_back(db_i);
                end
            end
            if (req_valid && e_ready) begin
                txn_q.push_back('{t, req_we, req_addr, req_rs0, req_wdata, 8'h00});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_bad = 0; checking = 1'b0;
        db_fix = 1'b0; db_fix_val = 8'h00;
        rst = 1'b1; req_valid = 1'b0;
        scramble();
        @(posedge clk);
        #1;
        checking = 1'b1;
        repeat (2) sync();
        rst = 1'b0;

        // Reset values, pinned by hand.
        @(negedge clk);
        check("rst_phi2", phi2_o, 1'b0);
        check("rst_cs1", cs1_o, 1'b0);
        check("rst_rw", rw_o, 1'b1);
        check("rst_db_oe", db_oe, 1'b0);
        check("rst_db_o", db_o, 8'h00);
        check("rst_addr", addr_o, 10'h000);
        check("rst_rdata", rsp_rdata, 8'h00);
`ifdef MOS6502_BUS_INITIATOR_RES_GEN_EN
        check("rst_res_n", res_n_o, 1'b0);
`endif
        repeat (DIV) @(negedge clk);
        check("phi2_first_high", phi2_o, 1'b1);
        repeat (PER) @(negedge clk);
        check("phi2_period", phi2_o, 1'b1);
        sync();

        // Write 0x3FF / RS0=1 / 0xA5.
        do_req(1'b1, 10'h3FF, 1'b1, 8'hA5);
        @(negedge clk);
        check("wr_addr", addr_o, 10'h3FF);
        check("wr_rs0", rs0_o, 1'b1);
        check("wr_rw", rw_o, 1'b0);
        check("wr_cs1", cs1_o, 1'b1);
        repeat (DIV) @(negedge clk);
        check("wr_oe_ph2", db_oe, 1'b1);
        check("wr_db", db_o, 8'hA5);
        repeat (DIV) @(negedge clk);
        check("wr_oe_hold", db_oe, 1'b1);
        check("wr_no_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        check("wr_oe_drop", db_oe, 1'b0);
        sync();

        // Read 0x200, responder returns 0x5A.
        db_fix = 1'b1; db_fix_val = 8'h5A;
        do_req(1'b0, 10'h200, 1'b0, 8'h00);
        repeat (PER + 1) @(negedge clk);
        check("rd_valid", rsp_valid, 1'b1);
        check("rd_data", rsp_rdata, 8'h5A);
        @(negedge clk);
        check("rd_pulse_end", rsp_valid, 1'b0);
        check("rd_data_hold", rsp_rdata, 8'h5A);
        db_fix = 1'b0;
        sync();

        // Back-to-back write 0x11 then read 0x000.
        db_fix = 1'b1; db_fix_val = 8'h3C;
        do_req(1'b1, 10'h155, 1'b0, 8'h11);
        do_req(1'b0, 10'h000, 1'b0, 8'h00);
        @(negedge clk);
        check("b2b_oe_overlap", db_oe, 1'b1);
        check("b2b_db_hold", db_o, 8'h11);
        check("b2b_rw_read", rw_o, 1'b1);
        check("b2b_cs1", cs1_o, 1'b1);
        @(negedge clk);
        check("b2b_oe_drop", db_oe, 1'b0);
        repeat (PER - 1) @(negedge clk);
        check("b2b_rd_valid", rsp_valid, 1'b1);
        check("b2b_rd_data", rsp_rdata, 8'h3C);
        db_fix = 1'b0;
        sync();

        // Reset in the middle of a write's PHI2.
        do_req(1'b1, 10'h0F0, 1'b1, 8'hC3);
        repeat (DIV + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_oe", db_oe, 1'b0);
        check("mid_rst_cs1", cs1_o, 1'b0);
        check("mid_rst_rw", rw_o, 1'b1);
        check("mid_rst_phi2", phi2_o, 1'b0);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        sync();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3 * DIV);
            repeat (gap) sync();
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                sync();
                rst = 1'b0;
            end
            do_req(1'($urandom), 10'($urandom), 1'($urandom), 8'($urandom));
        end

        repeat (3 * PER) sync();
        check("sb_drain", exp_q.size(), 0);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
